// File: rtl/rect_pkg.sv
// Shared widths, FSM state type, normalised-rectangle record and small
// unsigned min/max helpers for the rectangle plotter.
// Optional feature macro used by this block: RECT_OUTLINE_EN.
package rect_pkg;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Normalised, clipped rectangle plus its fill colour.
    typedef struct packed {
        logic [XW-1:0] xl;
        logic [XW-1:0] xr;
        logic [YW-1:0] yt;
        logic [YW-1:0] yb;
        logic [CW-1:0] colour;
    } rect_t;

    function automatic logic [8:0] umin9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [8:0] umax9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rect_plotter_if.sv
// Request / plot-port bundle between the control logic, the plotter and
// the VGA adapter. The outline request bit exists only when
// RECT_OUTLINE_EN is defined.
interface rect_plotter_if;
    import rect_pkg::*;

    logic          start;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [CW-1:0] colour_in;
`ifdef RECT_OUTLINE_EN
    logic          outline;
`endif
    logic          ready;
    logic          done;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    modport master (
`ifdef RECT_OUTLINE_EN
        output outline,
`endif
        output start, x0, x1, y0, y1, colour_in,
        input  ready, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
`ifdef RECT_OUTLINE_EN
        input  outline,
`endif
        input  start, x0, x1, y0, y1, colour_in,
        output ready, done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/rect_plotter_raster_counter.sv
// Row-major scan counter for the rectangle plotter. cx/cy are the pixel
// currently on the plot port; step advances to the next one. With
// skip_interior set, interior rows visit only the left and right columns.
module raster_counter
    import rect_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [XW-1:0] xl,
    input  logic [XW-1:0] xr,
    input  logic [YW-1:0] yt,
    input  logic [YW-1:0] yb,
    input  logic          skip_interior,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          last,
    output logic          wrap
);

    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          interior_s;

    // Next scan position: load to the top-left corner or advance one pixel.
    always_comb begin
        cx_d       = cx_q;
        cy_d       = cy_q;
        interior_s = (cy_q > yt) && (cy_q < yb);
        if (load) begin
            cx_d = xl;
            cy_d = yt;
        end else if (step) begin
            if (cx_q == xr) begin
                cx_d = xl;
                cy_d = cy_q + YW'(1);
            end else if (skip_interior && interior_s && (cx_q == xl)) begin
                cx_d = xr;
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end else begin
            cx_d = cx_q;
            cy_d = cy_q;
        end
    end

    // Scan position registers; these double as the registered vga_x/vga_y.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign wrap = (cx_q == xr);
    assign last = (cx_q == xr) && (cy_q == yb);

endmodule

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: accepts one rectangle per start handshake,
// normalises and clips it to the screen, then streams one plot command per
// clock in row-major order. RECT_OUTLINE_EN adds perimeter-only drawing.
module rect_plotter
    import rect_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clock,
    input  logic           reset,
    rect_plotter_if.slave  bus
);

    // 9-bit bounds so a 256-wide / 128-high screen does not wrap.
    localparam logic [8:0] XMAX9 = 9'(SCREEN_W - 1);
    localparam logic [8:0] YMAX9 = 9'(SCREEN_H - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [CW-1:0] colour_q, colour_d;
    logic          outline_q, outline_d;
    rect_t         bounds_q, bounds_d;
    logic          plot_q, plot_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    logic [8:0]    xl9_s, xr9_s, yt9_s, yb9_s;
    logic          empty_s;
    rect_t         norm_s;
    rect_t         cnt_bounds_s;
    logic          load_s, step_s;
    logic          last_s, wrap_s, final_pixel_s;
    logic [XW-1:0] cx_s;
    logic [YW-1:0] cy_s;

    // Order the latched corners and clip the far edges to the screen.
    always_comb begin
        xl9_s  = umin9({1'b0, x0_q}, {1'b0, x1_q});
        xr9_s  = umin9(umax9({1'b0, x0_q}, {1'b0, x1_q}), XMAX9);
        yt9_s  = umin9({2'b00, y0_q}, {2'b00, y1_q});
        yb9_s  = umin9(umax9({2'b00, y0_q}, {2'b00, y1_q}), YMAX9);
        empty_s = (xl9_s > XMAX9) || (yt9_s > YMAX9);
        norm_s.xl     = XW'(xl9_s);
        norm_s.xr     = XW'(xr9_s);
        norm_s.yt     = YW'(yt9_s);
        norm_s.yb     = YW'(yb9_s);
        norm_s.colour = colour_q;
    end

    // The counter loads straight from the normaliser during SETUP.
    always_comb begin
        if (state_q == SETUP) begin
            cnt_bounds_s = norm_s;
        end else begin
            cnt_bounds_s = bounds_q;
        end
    end

    // The final pixel always sits at a row wrap.
    assign final_pixel_s = wrap_s && last_s;

    // FSM next state, request latching and plot/done/ready generation.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        colour_d  = colour_q;
        outline_d = outline_q;
        bounds_d  = bounds_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;
        load_s    = 1'b0;
        step_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d     = bus.x0;
                    x1_d     = bus.x1;
                    y0_d     = bus.y0;
                    y1_d     = bus.y1;
                    colour_d = bus.colour_in;
`ifdef RECT_OUTLINE_EN
                    outline_d = bus.outline;
`else
                    outline_d = 1'b0;
`endif
                    state_d  = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (empty_s) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    bounds_d = norm_s;
                    load_s   = 1'b1;
                    plot_d   = 1'b1;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (final_pixel_s) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    step_s  = 1'b1;
                    plot_d  = 1'b1;
                    state_d = DRAW;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State, latched request and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            colour_q  <= '0;
            outline_q <= 1'b0;
            bounds_q  <= '0;
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            colour_q  <= colour_d;
            outline_q <= outline_d;
            bounds_q  <= bounds_d;
            plot_q    <= plot_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    raster_counter u_counter (
        .clock         (clock),
        .reset         (reset),
        .load          (load_s),
        .step          (step_s),
        .xl            (cnt_bounds_s.xl),
        .xr            (cnt_bounds_s.xr),
        .yt            (cnt_bounds_s.yt),
        .yb            (cnt_bounds_s.yb),
        .skip_interior (outline_q),
        .cx            (cx_s),
        .cy            (cy_s),
        .last          (last_s),
        .wrap          (wrap_s)
    );

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = cx_s;
    assign bus.vga_y      = cy_s;
    assign bus.vga_colour = bounds_q.colour;

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed vector table, a reset
// abort sequence and randomized rectangles, all checked cycle by cycle
// against a pixel-list model built from the clipping/scan rules.
module tb_rect_plotter;

    localparam int W = 160;
    localparam int H = 120;
`ifdef RECT_OUTLINE_EN
    localparam bit OUTLINE_BUILT = 1'b1;
`else
    localparam bit OUTLINE_BUILT = 1'b0;
`endif

    typedef struct {
        logic [7:0] x0;
        logic [7:0] x1;
        logic [6:0] y0;
        logic [6:0] y1;
        logic [2:0] col;
        logic       ol;
        int         n;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    vec_t tbl[$];

    rect_plotter_if bus ();

    rect_plotter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] status();
        return {bus.ready, bus.done, bus.vga_plot};
    endfunction

    // Issue one request and check every cycle up to the return of ready.
    task automatic run_rect(input logic [7:0] ax0, input logic [7:0] ax1,
                            input logic [6:0] ay0, input logic [6:0] ay1,
                            input logic [2:0] col, input logic ol,
                            input string tag, output int nplots);
        int xl, xr, yt, yb, n;
        logic ol_eff;
        logic [14:0] exp_q[$];
        ol_eff = ol & OUTLINE_BUILT;
        xl = (ax0 < ax1) ? int'(ax0) : int'(ax1);
        xr = (ax0 > ax1) ? int'(ax0) : int'(ax1);
        yt = (ay0 < ay1) ? int'(ay0) : int'(ay1);
        yb = (ay0 > ay1) ? int'(ay0) : int'(ay1);
        if (xr > W - 1) xr = W - 1;
        if (yb > H - 1) yb = H - 1;
        if (xl <= W - 1 && yt <= H - 1) begin
            for (int y = yt; y <= yb; y++)
                for (int x = xl; x <= xr; x++)
                    if (!ol_eff || y == yt || y == yb || x == xl || x == xr)
                        exp_q.push_back({8'(x), 7'(y)});
        end
        n = exp_q.size();

        @(posedge clock); #1;
        check({tag, " idle"}, 32'(status()), 32'(3'b100));
        bus.start = 1'b1;
        bus.x0 = ax0; bus.x1 = ax1; bus.y0 = ay0; bus.y1 = ay1;
        bus.colour_in = col;
`ifdef RECT_OUTLINE_EN
        bus.outline = ol;
`endif
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.x0 = 8'($urandom); bus.x1 = 8'($urandom);
        bus.y0 = 7'($urandom); bus.y1 = 7'($urandom);
        bus.colour_in = 3'($urandom);
        check({tag, " setup"}, 32'(status()), 32'(3'b000));

        nplots = 0;
        for (int i = 0; i < n; i++) begin
            bus.start = 1'($urandom);
            @(posedge clock); #1;
            if (bus.vga_plot) nplots++;
            check($sformatf("%s pix%0d", tag, i),
                  32'({status(), bus.vga_x, bus.vga_y, bus.vga_colour}),
                  32'({3'b001, exp_q[i], col}));
        end
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check({tag, " done"}, 32'(status()), 32'(3'b010));
        if (n > 0)
            check({tag, " hold"}, 32'({bus.vga_x, bus.vga_y}), 32'(exp_q[n-1]));
        @(posedge clock); #1;
        check({tag, " ready"}, 32'(status()), 32'(3'b100));
    endtask

    initial begin
        int np;
        int bad;
        checks = 0;
        failures = 0;
        bus.start = 1'b0;
        bus.x0 = 8'd0; bus.x1 = 8'd0; bus.y0 = 7'd0; bus.y1 = 7'd0;
        bus.colour_in = 3'd0;
`ifdef RECT_OUTLINE_EN
        bus.outline = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 32'({status(), bus.vga_x, bus.vga_y, bus.vga_colour}),
              32'({3'b100, 18'd0}));
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset", 32'({status(), bus.vga_x, bus.vga_y, bus.vga_colour}),
              32'({3'b100, 18'd0}));

        tbl.push_back('{8'd10,  8'd11,  7'd20,  7'd21,  3'd5, 1'b0, 4});
        tbl.push_back('{8'd11,  8'd10,  7'd21,  7'd20,  3'd5, 1'b0, 4});
        tbl.push_back('{8'd158, 8'd170, 7'd118, 7'd127, 3'd2, 1'b0, 4});
        tbl.push_back('{8'd200, 8'd210, 7'd5,   7'd6,   3'd7, 1'b0, 0});
        tbl.push_back('{8'd0,   8'd0,   7'd0,   7'd0,   3'd1, 1'b0, 1});
        tbl.push_back('{8'd160, 8'd170, 7'd0,   7'd3,   3'd4, 1'b0, 0});
        tbl.push_back('{8'd3,   8'd3,   7'd125, 7'd120, 3'd4, 1'b0, 0});
        tbl.push_back('{8'd159, 8'd159, 7'd119, 7'd119, 3'd6, 1'b0, 1});
        tbl.push_back('{8'd0,   8'd255, 7'd0,   7'd0,   3'd3, 1'b0, 160});
        tbl.push_back('{8'd5,   8'd5,   7'd127, 7'd0,   3'd2, 1'b0, 120});
`ifdef RECT_OUTLINE_EN
        tbl.push_back('{8'd0,   8'd3,   7'd0,   7'd2,   3'd5, 1'b1, 10});
        tbl.push_back('{8'd0,   8'd3,   7'd0,   7'd2,   3'd5, 1'b0, 12});
        tbl.push_back('{8'd9,   8'd8,   7'd4,   7'd9,   3'd1, 1'b1, 12});
        tbl.push_back('{8'd20,  8'd25,  7'd40,  7'd41,  3'd3, 1'b1, 12});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            run_rect(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].col,
                     tbl[i].ol, $sformatf("vec%0d", i), np);
            check($sformatf("vec%0d count", i), 32'(np), 32'(tbl[i].n));
        end

        // Reset while the third pixel of a 4x4 fill is on the port.
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.x0 = 8'd20; bus.x1 = 8'd23; bus.y0 = 7'd30; bus.y1 = 7'd33;
        bus.colour_in = 3'd6;
`ifdef RECT_OUTLINE_EN
        bus.outline = 1'b0;
`endif
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("rst pix3", 32'({status(), bus.vga_x, bus.vga_y, bus.vga_colour}),
              32'({3'b001, 8'd22, 7'd30, 3'd6}));
        reset = 1'b1;
        #1;
        check("rst async", 32'({bus.done, bus.vga_plot}), 32'(2'b00));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst release", 32'(status()), 32'(3'b100));
        bad = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (status() !== 3'b100) bad++;
        end
        check("rst quiet", 32'(bad), 32'd0);
        run_rect(8'd0, 8'd0, 7'd0, 7'd0, 3'd3, 1'b0, "after_rst", np);
        check("after_rst count", 32'(np), 32'd1);

        // Randomized small rectangles anywhere on (and off) the screen.
        for (int r = 0; r < 25; r++) begin
            int a, b, c, d;
            a = int'($urandom_range(255, 0));
            b = a + int'($urandom_range(12, 0)) - 6;
            if (b < 0) b = 0;
            if (b > 255) b = 255;
            c = int'($urandom_range(127, 0));
            d = c + int'($urandom_range(8, 0)) - 4;
            if (d < 0) d = 0;
            if (d > 127) d = 127;
            run_rect(8'(a), 8'(b), 7'(c), 7'(d), 3'($urandom), 1'($urandom),
                     $sformatf("rnd%0d", r), np);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
